// File: rtl/ins_mem_loader.sv
// ins_mem_loader
//   Streams 32-bit instruction words into a byte-wide instruction memory.
//   Each accepted word is written one byte per clock in big-endian order.
//   A combinational big-endian word read port serves the fetch side.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset (control only, memory kept)
//   wr_valid     : write request presented
//   wr_ready     : loader idle, can accept a request
//   wr_addr      : word-aligned byte address of the word to write
//   wr_data      : instruction word to write
//   busy         : request in progress (== !wr_ready)
//   done         : one-cycle pulse after a word is fully written
//   err          : one-cycle pulse after a request is rejected
//   loaded_words : count of words written, saturating at 16'hFFFF
//   InsAddr      : read byte address
//   InsData      : big-endian word at InsAddr, out-of-range bytes read 0
module ins_mem_loader #(
  parameter int unsigned DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] loaded_words,
  input  logic [31:0] InsAddr,
  output logic [31:0] InsData
);

  localparam int unsigned AW = (DEPTH > 4) ? $clog2(DEPTH) : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [15:0]     loaded_words_q, loaded_words_d;

  logic [7:0]      mem [DEPTH];

  logic [32:0]     last_byte;
  logic            addr_bad;
  logic            we;
  logic [1:0]      woff;
  logic [7:0]      wbyte;
  logic [AW-1:0]   widx;
  logic [32:0]     ridx;

  // 33-bit sum so an address near 2^32 cannot wrap into range.
  assign last_byte = {1'b0, wr_addr} + 33'd3;
  assign addr_bad  = (wr_addr[1:0] != 2'b00) || (last_byte > 33'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      loaded_words_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      loaded_words_q <= loaded_words_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    loaded_words_d = loaded_words_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_valid) begin
          // Only AW address bits are kept; the range check guarantees the
          // discarded upper bits are zero for accepted requests.
          addr_d  = wr_addr[AW-1:0];
          data_d  = wr_data;
          state_d = addr_bad ? S_ERR : S_WR0;
        end
      end
      S_WR0: state_d = S_WR1;
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: state_d = S_DONE;
      S_DONE: begin
        if (loaded_words_q != 16'hFFFF) begin
          loaded_words_d = loaded_words_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte lane selection for the write states: WRk stores data[31-8k -: 8]
  // at addr+k.
  always_comb begin
    we    = 1'b0;
    woff  = 2'd0;
    wbyte = data_q[31:24];
    unique case (state_q)
      S_WR0: begin we = 1'b1; woff = 2'd0; wbyte = data_q[31:24]; end
      S_WR1: begin we = 1'b1; woff = 2'd1; wbyte = data_q[23:16]; end
      S_WR2: begin we = 1'b1; woff = 2'd2; wbyte = data_q[15:8];  end
      S_WR3: begin we = 1'b1; woff = 2'd3; wbyte = data_q[7:0];   end
      default: ;
    endcase
  end

  assign widx = addr_q + AW'(woff);

  // Memory has no reset: contents survive a reset issued mid-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wbyte;
    end
  end

  always_comb begin
    InsData = '0;
    ridx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ridx = {1'b0, InsAddr} + 33'(i);
      if (ridx < 33'(DEPTH)) begin
        InsData[31-8*i -: 8] = mem[ridx[AW-1:0]];
      end
    end
  end

  assign wr_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign loaded_words = loaded_words_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
module tb_ins_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] loaded_words;
  logic [31:0] InsAddr;
  logic [31:0] InsData;

  int asserts = 0;
  int fails   = 0;

  ins_mem_loader #(.DEPTH(512)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .loaded_words (loaded_words),
    .InsAddr      (InsAddr),
    .InsData      (InsData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Drives one request and observes it for 12 cycles. Cycle 1 is the
  // negedge right after the accepting edge E0.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       output int done_cyc, output int done_cnt,
                       output int err_cyc, output logic busy_mid,
                       output logic [31:0] data_at_done);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_addr  = 32'hDEAD_BEEF;
    wr_data  = 32'h0BAD_0BAD;
    done_cyc = 0;
    done_cnt = 0;
    err_cyc  = 0;
    busy_mid = 1'b0;
    data_at_done = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) busy_mid = busy && !wr_ready;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          data_at_done = InsData;
        end
      end
      if (err === 1'b1 && err_cyc == 0) err_cyc = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    asserts++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    asserts++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    asserts++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    asserts++; if (loaded_words !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h expected 0000", loaded_words); end
  endtask

  task automatic test_single_write();
    int dc, dn, ec; logic bm; logic [31:0] dd;
    InsAddr = 32'd0;
    issue(32'd0, 32'h1234_5678, dc, dn, ec, bm, dd);
    asserts++; if (dc !== 5) begin fails++; $display("FAIL single_done_latency: got %0d expected 5", dc); end
    asserts++; if (dn !== 1) begin fails++; $display("FAIL single_done_width: got %0d expected 1", dn); end
    asserts++; if (ec !== 0) begin fails++; $display("FAIL single_no_err: got %0d expected 0", ec); end
    asserts++; if (bm !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", bm); end
    asserts++; if (dd !== 32'h1234_5678) begin fails++; $display("FAIL single_data_at_done: got %h expected 12345678", dd); end
    asserts++; if (loaded_words !== 16'd1) begin fails++; $display("FAIL single_count: got %h expected 0001", loaded_words); end
    InsAddr = 32'd0; #1;
    asserts++; if (InsData !== 32'h1234_5678) begin fails++; $display("FAIL single_read: got %h expected 12345678", InsData); end
  endtask

  task automatic test_overlap_read();
    int dc, dn, ec; logic bm; logic [31:0] dd;
    issue(32'd4, 32'hAABB_CCDD, dc, dn, ec, bm, dd);
    asserts++; if (dc !== 5) begin fails++; $display("FAIL overlap_done_latency: got %0d expected 5", dc); end
    InsAddr = 32'd2; #1;
    asserts++; if (InsData !== 32'h5678_AABB) begin fails++; $display("FAIL read_addr2: got %h expected 5678aabb", InsData); end
    InsAddr = 32'd4; #1;
    asserts++; if (InsData !== 32'hAABB_CCDD) begin fails++; $display("FAIL read_addr4: got %h expected aabbccdd", InsData); end
    asserts++; if (loaded_words !== 16'd2) begin fails++; $display("FAIL overlap_count: got %h expected 0002", loaded_words); end
  endtask

  task automatic test_boundary();
    int dc, dn, ec; logic bm; logic [31:0] dd;
    issue(32'd2, 32'hFFFF_FFFF, dc, dn, ec, bm, dd);
    asserts++; if (ec !== 1) begin fails++; $display("FAIL misaligned_err: got %0d expected 1", ec); end
    asserts++; if (dc !== 0) begin fails++; $display("FAIL misaligned_no_done: got %0d expected 0", dc); end
    asserts++; if (loaded_words !== 16'd2) begin fails++; $display("FAIL misaligned_count: got %h expected 0002", loaded_words); end
    InsAddr = 32'd2; #1;
    asserts++; if (InsData !== 32'h5678_AABB) begin fails++; $display("FAIL misaligned_mem: got %h expected 5678aabb", InsData); end

    issue(32'd508, 32'h0102_0304, dc, dn, ec, bm, dd);
    asserts++; if (dc !== 5 || ec !== 0) begin fails++; $display("FAIL top_word_accept: got done %0d err %0d expected done 5 err 0", dc, ec); end
    InsAddr = 32'd508; #1;
    asserts++; if (InsData !== 32'h0102_0304) begin fails++; $display("FAIL top_word_read: got %h expected 01020304", InsData); end
    asserts++; if (loaded_words !== 16'd3) begin fails++; $display("FAIL top_word_count: got %h expected 0003", loaded_words); end

    issue(32'd512, 32'h5555_5555, dc, dn, ec, bm, dd);
    asserts++; if (ec !== 1 || dc !== 0) begin fails++; $display("FAIL addr512_err: got err %0d done %0d expected err 1 done 0", ec, dc); end

    issue(32'hFFFF_FFFC, 32'h6666_6666, dc, dn, ec, bm, dd);
    asserts++; if (ec !== 1 || dc !== 0) begin fails++; $display("FAIL addr_wrap_err: got err %0d done %0d expected err 1 done 0", ec, dc); end
    asserts++; if (loaded_words !== 16'd3) begin fails++; $display("FAIL reject_count: got %h expected 0003", loaded_words); end

    InsAddr = 32'd510; #1;
    asserts++; if (InsData !== 32'h0304_0000) begin fails++; $display("FAIL read_510: got %h expected 03040000", InsData); end
    InsAddr = 32'd0; #1;
    asserts++; if (InsData !== 32'h1234_5678) begin fails++; $display("FAIL reject_mem0: got %h expected 12345678", InsData); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    int   acc_t [3];
    int   n;
    int   t;
    logic acc;
    addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd8;
    words[0] = 32'h1122_3344; words[1] = 32'h5566_7788; words[2] = 32'h99AA_BBCC;
    acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
    do_reset();
    n = 0;
    t = 0;
    wr_valid = 1'b1;
    wr_addr  = addrs[0];
    wr_data  = words[0];
    while (n < 3 && t < 40) begin
      acc = wr_ready;
      @(posedge clk);
      t++;
      if (acc) begin
        acc_t[n] = t;
        n++;
      end
      @(negedge clk);
      if (acc && n < 3) begin
        wr_addr = addrs[n];
        wr_data = words[n];
      end
    end
    wr_valid = 1'b0;
    repeat (8) @(negedge clk);
    asserts++; if (n !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", n); end
    asserts++; if (acc_t[1] - acc_t[0] !== 6) begin fails++; $display("FAIL b2b_gap01: got %0d expected 6", acc_t[1] - acc_t[0]); end
    asserts++; if (acc_t[2] - acc_t[1] !== 6) begin fails++; $display("FAIL b2b_gap12: got %0d expected 6", acc_t[2] - acc_t[1]); end
    for (int i = 0; i < 3; i++) begin
      InsAddr = addrs[i]; #1;
      asserts++; if (InsData !== words[i]) begin fails++; $display("FAIL b2b_read%0d: got %h expected %h", i, InsData, words[i]); end
    end
    asserts++; if (loaded_words !== 16'd3) begin fails++; $display("FAIL b2b_count: got %h expected 0003", loaded_words); end
  endtask

  task automatic test_reset_mid_write();
    int dc, dn, ec; logic bm; logic [31:0] dd;
    int dseen;
    int eseen;
    issue(32'd16, 32'h0102_0304, dc, dn, ec, bm, dd);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = 32'd16;
    wr_data  = 32'hCAFE_BABE;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    asserts++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midreset_idle: got ready %b busy %b expected ready 1 busy 0", wr_ready, busy); end
    asserts++; if (loaded_words !== 16'd0) begin fails++; $display("FAIL midreset_count: got %h expected 0000", loaded_words); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    dseen = 0;
    eseen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) dseen++;
      if (err === 1'b1) eseen++;
    end
    asserts++; if (dseen !== 0 || eseen !== 0) begin fails++; $display("FAIL midreset_pulses: got done %0d err %0d expected 0 0", dseen, eseen); end
    InsAddr = 32'd16; #1;
    asserts++; if (InsData !== 32'hCA02_0304) begin fails++; $display("FAIL midreset_mem: got %h expected ca020304", InsData); end
    asserts++; if (loaded_words !== 16'd0) begin fails++; $display("FAIL midreset_count_after: got %h expected 0000", loaded_words); end
  endtask

  task automatic test_saturation();
    int dc, dn, ec; logic bm; logic [31:0] dd;
    @(negedge clk);
    force dut.loaded_words_q = 16'hFFFE;
    #1;
    release dut.loaded_words_q;
    issue(32'd20, 32'h0BAD_F00D, dc, dn, ec, bm, dd);
    asserts++; if (loaded_words !== 16'hFFFF) begin fails++; $display("FAIL sat_reach: got %h expected ffff", loaded_words); end
    issue(32'd24, 32'hFEED_FACE, dc, dn, ec, bm, dd);
    asserts++; if (dc !== 5) begin fails++; $display("FAIL sat_done: got %0d expected 5", dc); end
    asserts++; if (loaded_words !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h expected ffff", loaded_words); end
    InsAddr = 32'd24; #1;
    asserts++; if (InsData !== 32'hFEED_FACE) begin fails++; $display("FAIL sat_read: got %h expected feedface", InsData); end
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    InsAddr  = '0;
    test_reset();
    test_single_write();
    test_overlap_read();
    test_boundary();
    test_back_to_back();
    test_reset_mid_write();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
